// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types for the APB master: bit positions of the
//                one-hot FSM, the one-hot state encoding itself, and the
//                response record returned to the command side.
//  Contents    : state_idx_e  - bit index of each state in the one-hot vector
//                state_e      - one-hot state encoding (4 bits)
//                rsp_t        - {rdata, err, timeout} response record
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Widest read data the response record can carry; the master's
    // DATA_WIDTH must not exceed this.
    localparam int c_max_data_width = 32;

    typedef enum logic [1:0] {
        IDLE_B   = 2'd0,
        SETUP_B  = 2'd1,
        ACCESS_B = 2'd2,
        RESP_B   = 2'd3
    } state_idx_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_SETUP  = 4'b0010,
        S_ACCESS = 4'b0100,
        S_RESP   = 4'b1000
    } state_e;

    typedef struct packed {
        logic [c_max_data_width-1:0] rdata;
        logic                        err;
        logic                        timeout;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_if
//  Description : Bundles the command, response and APB bus signals of the
//                APB master. Signal names carry the direction as seen from
//                the master (I_ = into the master, O_ = out of the master).
//  Modports    : master - the apb_master view
//                slave  - the environment view (command source, response
//                         sink and APB completer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) ();
    // command channel
    logic                  I_CMD_VALID;
    logic                  O_CMD_READY;
    logic [ADDR_WIDTH-1:0] I_CMD_ADDR;
    logic                  I_CMD_WRITE;
    logic [DATA_WIDTH-1:0] I_CMD_WDATA;
    // response channel
    logic                  O_RSP_VALID;
    logic                  I_RSP_READY;
    logic [DATA_WIDTH-1:0] O_RSP_RDATA;
    logic                  O_RSP_ERR;
    logic                  O_RSP_TIMEOUT;
    // APB bus
    logic [ADDR_WIDTH-1:0] O_PADDR;
    logic                  O_PSEL;
    logic                  O_PENABLE;
    logic                  O_PWRITE;
    logic [DATA_WIDTH-1:0] O_PWDATA;
    logic                  I_PREADY;
    logic [DATA_WIDTH-1:0] I_PRDATA;
    logic                  I_PSLVERR;

    modport master (
        input  I_CMD_VALID, I_CMD_ADDR, I_CMD_WRITE, I_CMD_WDATA, I_RSP_READY,
               I_PREADY, I_PRDATA, I_PSLVERR,
        output O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR, O_RSP_TIMEOUT,
               O_PADDR, O_PSEL, O_PENABLE, O_PWRITE, O_PWDATA
    );

    modport slave (
        output I_CMD_VALID, I_CMD_ADDR, I_CMD_WRITE, I_CMD_WDATA, I_RSP_READY,
               I_PREADY, I_PRDATA, I_PSLVERR,
        input  O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR, O_RSP_TIMEOUT,
               O_PADDR, O_PSEL, O_PENABLE, O_PWRITE, O_PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_timeout_counter
//  Description : Counts ACCESS wait cycles. expired_o flags the wait cycle
//                that brings the count to TIMEOUT_CYCLES, so the owner can
//                abort on that same edge. TIMEOUT_CYCLES = 0 disables it.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                clear_i   - restart the count (has priority over enable_i)
//                enable_i  - this cycle is a wait cycle
//                expired_o - this wait cycle reaches the limit
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear_i,
    input  wire logic enable_i,
    output logic      expired_o
);

    localparam bit c_enabled = (TIMEOUT_CYCLES > 0);
    localparam int c_limit   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
    localparam int c_cnt_w   = (c_limit > 1) ? $clog2(c_limit) : 1;
    // The count only needs to hold limit-1 wait cycles already seen; the
    // limit-th wait cycle is recognised combinationally.
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_limit - 1);

    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != c_last)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = c_enabled && enable_i && (count_q == c_last);

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master
//  Description : Single-outstanding APB master. Takes one command through a
//                valid/ready handshake, runs the SETUP/ACCESS phases on APB,
//                and holds the response until it is consumed. Wait states are
//                bounded by an optional timeout.
//  Ports       : I_PCLK    - clock, rising edge
//                I_PRESETN - asynchronous active-low reset
//                bus       - apb_master_if.master: command, response and
//                            APB bus signals
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic     I_PCLK,
    input  wire logic     I_PRESETN,
    apb_master_if.master  bus
);

    state_e                state_q,   state_d;
    logic                  psel_q,    psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q,  pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
    logic                  rsp_vld_q, rsp_vld_d;
    rsp_t                  rsp_q,     rsp_d;

    logic w_cmd_fire;
    logic w_wait_cycle;
    logic w_expired;

    assign w_cmd_fire   = state_q[IDLE_B] && bus.I_CMD_VALID;
    assign w_wait_cycle = state_q[ACCESS_B] && !bus.I_PREADY;

    // Counter restarts on every accepted command, i.e. on entry to SETUP.
    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (I_PCLK),
        .rst_n     (I_PRESETN),
        .clear_i   (w_cmd_fire),
        .enable_i  (w_wait_cycle),
        .expired_o (w_expired)
    );

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rsp_vld_d = rsp_vld_q;
        rsp_d     = rsp_q;

        case (state_q)
            S_IDLE: begin
                if (bus.I_CMD_VALID) begin
                    paddr_d   = bus.I_CMD_ADDR;
                    pwrite_d  = bus.I_CMD_WRITE;
                    pwdata_d  = bus.I_CMD_WDATA;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                // PREADY is checked first so a completing slave wins over
                // a timeout landing on the same edge.
                if (bus.I_PREADY) begin
                    rsp_d.rdata = '0;
                    if (!pwrite_q) begin
                        rsp_d.rdata[DATA_WIDTH-1:0] = bus.I_PRDATA;
                    end
                    rsp_d.err     = bus.I_PSLVERR;
                    rsp_d.timeout = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_vld_d     = 1'b1;
                    state_d       = S_RESP;
                end else if (w_expired) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_vld_d     = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.I_RSP_READY) begin
                    rsp_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                // Non-one-hot state: drop off the bus and restart.
                psel_d    = 1'b0;
                penable_d = 1'b0;
                rsp_vld_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_PCLK or negedge I_PRESETN) begin
        if (!I_PRESETN) begin
            state_q   <= S_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_q     <= rsp_d;
        end
    end

    assign bus.O_CMD_READY   = state_q[IDLE_B];
    assign bus.O_PSEL        = psel_q;
    assign bus.O_PENABLE     = penable_q;
    assign bus.O_PWRITE      = pwrite_q;
    assign bus.O_PADDR       = paddr_q;
    assign bus.O_PWDATA      = pwdata_q;
    assign bus.O_RSP_VALID   = rsp_vld_q;
    assign bus.O_RSP_RDATA   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign bus.O_RSP_ERR     = rsp_q.err;
    assign bus.O_RSP_TIMEOUT = rsp_q.timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master
//  Description : Self-checking bench for apb_master (TIMEOUT_CYCLES = 4).
//                Directed stimulus pushes expected responses into a queue;
//                a monitor pops and compares each accepted response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .I_PCLK    (clk),
        .I_PRESETN (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    rsp_t sb_q[$];
    rsp_t mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // ---------------- APB completer model ----------------
    int          acc_cnt   = 0;
    int          slv_wait  = 0;
    bit          slv_stuck = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;

    always @(negedge clk) begin
        if (bus.O_PSEL && bus.O_PENABLE) begin
            if (!slv_stuck && acc_cnt >= slv_wait) begin
                bus.I_PREADY  = 1'b1;
                bus.I_PRDATA  = slv_rdata;
                bus.I_PSLVERR = slv_err;
            end else begin
                // garbage while not ready: must never be sampled
                bus.I_PREADY  = 1'b0;
                bus.I_PRDATA  = 32'hBADBADBA;
                bus.I_PSLVERR = 1'b1;
            end
            acc_cnt++;
        end else begin
            bus.I_PREADY  = 1'b0;
            bus.I_PRDATA  = '0;
            bus.I_PSLVERR = 1'b0;
            acc_cnt       = 0;
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.O_RSP_VALID && bus.I_RSP_READY) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: actual=response required=none");
            end else begin
                mon_exp = sb_q.pop_front();
                check("rsp_rdata",   bus.O_RSP_RDATA,   mon_exp.rdata);
                check("rsp_err",     bus.O_RSP_ERR,     mon_exp.err);
                check("rsp_timeout", bus.O_RSP_TIMEOUT, mon_exp.timeout);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Returns at the falling edge of the SETUP cycle (N+1), valid dropped.
    task automatic issue(input logic [15:0] a, input logic w, input logic [31:0] wd,
                         input bit push, input rsp_t e);
        int k;
        @(negedge clk);
        bus.I_CMD_VALID = 1'b1;
        bus.I_CMD_ADDR  = a;
        bus.I_CMD_WRITE = w;
        bus.I_CMD_WDATA = wd;
        k = 0;
        while (!bus.O_CMD_READY && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!bus.O_CMD_READY) begin
            n_checks++;
            $display("FAIL cmd_accept: actual=ready_low required=ready_high");
            bus.I_CMD_VALID = 1'b0;
            return;
        end
        if (push) sb_q.push_back(e);
        @(negedge clk);
        bus.I_CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (!(bus.O_CMD_READY && !bus.O_RSP_VALID) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!(bus.O_CMD_READY && !bus.O_RSP_VALID)) begin
            n_checks++;
            $display("FAIL wait_idle: actual=busy required=idle");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},    bus.O_PSEL,          0);
        check({tag, "_penable"}, bus.O_PENABLE,       0);
        check({tag, "_pwrite"},  bus.O_PWRITE,        0);
        check({tag, "_paddr"},   bus.O_PADDR,         0);
        check({tag, "_pwdata"},  bus.O_PWDATA,        0);
        check({tag, "_rspv"},    bus.O_RSP_VALID,     0);
        check({tag, "_rdata"},   bus.O_RSP_RDATA,     0);
        check({tag, "_err"},     bus.O_RSP_ERR,       0);
        check({tag, "_tmo"},     bus.O_RSP_TIMEOUT,   0);
        check({tag, "_cmdrdy"},  bus.O_CMD_READY,     1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        int  acc;
        int  k;
        bit  stable;
        bit  seen;

        bus.I_CMD_VALID = 1'b0;
        bus.I_CMD_ADDR  = '0;
        bus.I_CMD_WRITE = 1'b0;
        bus.I_CMD_WDATA = '0;
        bus.I_RSP_READY = 1'b1;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // zero-wait write: PSEL at N+1, PENABLE at N+2, RSP_VALID at N+3
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h55AA55AA;
        issue(16'h0004, 1'b1, 32'hDEADBEEF, 1'b1, '{32'h0, 1'b0, 1'b0});
        check("w_n1_psel",    bus.O_PSEL,        1);
        check("w_n1_penable", bus.O_PENABLE,     0);
        check("w_n1_paddr",   bus.O_PADDR,       32'h0004);
        check("w_n1_pwrite",  bus.O_PWRITE,      1);
        check("w_n1_pwdata",  bus.O_PWDATA,      32'hDEADBEEF);
        check("w_n1_cmdrdy",  bus.O_CMD_READY,   0);
        @(negedge clk);
        check("w_n2_psel",    bus.O_PSEL,        1);
        check("w_n2_penable", bus.O_PENABLE,     1);
        check("w_n2_rspv",    bus.O_RSP_VALID,   0);
        @(negedge clk);
        check("w_n3_rspv",    bus.O_RSP_VALID,   1);
        check("w_n3_psel",    bus.O_PSEL,        0);
        wait_idle();

        // read with 3 wait states: address stable, 4 ACCESS cycles
        slv_wait = 3; slv_rdata = 32'h12345678; slv_err = 1'b0;
        issue(16'h0008, 1'b0, 32'h0, 1'b1, '{32'h12345678, 1'b0, 1'b0});
        acc = 0; stable = 1'b1; k = 0;
        while (bus.O_PSEL && k < 20) begin
            if (bus.O_PADDR !== 16'h0008 || bus.O_PWRITE !== 1'b0) stable = 1'b0;
            if (bus.O_PENABLE) acc++;
            @(negedge clk);
            k++;
        end
        check("rd_paddr_stable", stable, 1);
        check("rd_access_cycles", acc, 4);
        wait_idle();

        // slave error on out-of-range read
        slv_wait = 0; slv_rdata = 32'h0; slv_err = 1'b1;
        issue(16'hFFFC, 1'b0, 32'h0, 1'b1, '{32'h0, 1'b1, 1'b0});
        wait_idle();
        slv_err = 1'b0;

        // stuck slave: abort after 4 ACCESS cycles
        slv_stuck = 1'b1;
        issue(16'h0030, 1'b0, 32'h0, 1'b1, '{32'h0, 1'b1, 1'b1});
        acc = 0; k = 0;
        while (bus.O_PSEL && k < 40) begin
            if (bus.O_PENABLE) acc++;
            @(negedge clk);
            k++;
        end
        check("tmo_access_cycles", acc, TO);
        check("tmo_psel",          bus.O_PSEL,      0);
        check("tmo_rspv",          bus.O_RSP_VALID, 1);
        wait_idle();
        slv_stuck = 1'b0;

        // response back-pressure with a second command waiting
        bus.I_RSP_READY = 1'b0;
        slv_wait = 0; slv_rdata = 32'hA5A55A5A;
        issue(16'h0010, 1'b0, 32'h0, 1'b1, '{32'hA5A55A5A, 1'b0, 1'b0});
        bus.I_CMD_VALID = 1'b1;
        bus.I_CMD_ADDR  = 16'h0020;
        bus.I_CMD_WRITE = 1'b1;
        bus.I_CMD_WDATA = 32'hCAFEF00D;
        sb_q.push_back('{32'h0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_rspv",   bus.O_RSP_VALID, 1);
            check("bp_rdata",  bus.O_RSP_RDATA, 32'hA5A55A5A);
            check("bp_cmdrdy", bus.O_CMD_READY, 0);
            check("bp_psel",   bus.O_PSEL,      0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.I_RSP_READY = 1'b1;
        @(negedge clk);            // monitor consumes here
        @(negedge clk);
        check("bp_idle_cmdrdy", bus.O_CMD_READY, 1);
        check("bp_idle_psel",   bus.O_PSEL,      0);
        @(negedge clk);
        check("bp_b_psel",  bus.O_PSEL,    1);
        check("bp_b_paddr", bus.O_PADDR,   32'h0020);
        check("bp_b_pwdata", bus.O_PWDATA, 32'hCAFEF00D);
        bus.I_CMD_VALID = 1'b0;
        wait_idle();

        // asynchronous reset in the middle of ACCESS
        slv_stuck = 1'b1;
        issue(16'h0040, 1'b1, 32'h11112222, 1'b0, '{32'h0, 1'b0, 1'b0});
        @(negedge clk);
        check("ar_in_access", bus.O_PENABLE, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("ar");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slv_stuck = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.O_RSP_VALID || bus.O_PSEL) seen = 1'b1;
        end
        check("ar_no_rsp", seen, 0);

        // recovery transfer after reset
        slv_wait = 1; slv_rdata = 32'h0F0F0F0F;
        issue(16'h0044, 1'b0, 32'h0, 1'b1, '{32'h0F0F0F0F, 1'b0, 1'b0});
        wait_idle();

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
